// File: rtl/reg_file_wr_demux_pkg.sv
// Shared widths and constants for the CPU register file and its write demux.
package reg_file_wr_demux_pkg;

  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int unsigned R0         = 0;

  typedef logic [REG_DATA_W-1:0] reg_word_t;

endpackage

// File: rtl/reg_file_wr_demux_demux.sv
// 1-to-N write demultiplexer: turns a write request into a one-hot register enable.
module write_demux_1toN #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] enable
);

  always_comb begin
    enable = '0;
    if (wr_en) begin
      enable[wr_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_wr_demux.sv
// CPU register file: one demuxed write port, two combinational read ports with
// optional same-cycle write forwarding and an optional hardwired-zero R0.
module reg_file_wr_demux
  import reg_file_wr_demux_pkg::*;
#(
  parameter int unsigned DATA_W   = REG_DATA_W,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              wr_err
);

  localparam int unsigned       N_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_R0 = ADDR_W'(R0);

  logic [N_REGS-1:0] w_reg_en;
  logic [DATA_W-1:0] w_regs [N_REGS];
  logic [DATA_W-1:0] w_rd_data1;
  logic [DATA_W-1:0] w_rd_data2;
  logic              w_byp1;
  logic              w_byp2;
  logic              w_r0_write;
  logic              r_wr_err;

  write_demux_1toN #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (N_REGS)
  ) u_demux (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .enable  (w_reg_en)
  );

  // Register array; a hardwired R0 never loads, so it stays at its reset value.
  for (genvar gi = 0; gi < int'(N_REGS); gi++) begin : g_reg
    localparam bit IS_ZERO = ZERO_REG && (gi == 0);
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (w_reg_en[gi] && !IS_ZERO) begin
        r_q <= wr_data;
      end
    end

    assign w_regs[gi] = r_q;
  end

  // Forwarding is gated by rst_n so reads stay 0 throughout reset.
  assign w_byp1 = BYPASS && rst_n && wr_en && (wr_addr == rd_addr1);
  assign w_byp2 = BYPASS && rst_n && wr_en && (wr_addr == rd_addr2);

  always_comb begin
    w_rd_data1 = w_regs[rd_addr1];
    if (w_byp1) begin
      w_rd_data1 = wr_data;
    end
    if (ZERO_REG && (rd_addr1 == ADDR_R0)) begin
      w_rd_data1 = '0;
    end
  end

  always_comb begin
    w_rd_data2 = w_regs[rd_addr2];
    if (w_byp2) begin
      w_rd_data2 = wr_data;
    end
    if (ZERO_REG && (rd_addr2 == ADDR_R0)) begin
      w_rd_data2 = '0;
    end
  end

  assign w_r0_write = ZERO_REG && wr_en && (wr_addr == ADDR_R0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_r0_write;
    end
  end

  assign rd_data1 = w_rd_data1;
  assign rd_data2 = w_rd_data2;
  assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_reg_file_wr_demux.sv
// Directed bench for reg_file_wr_demux: default build plus a BYPASS=0/ZERO_REG=0 build.
module tb_reg_file_wr_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_err, b_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  reg_file_wr_demux u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(a_rd1), .rd_data2(a_rd2),
    .wr_err(a_err)
  );

  reg_file_wr_demux #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(b_rd1), .rd_data2(b_rd2),
    .wr_err(b_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = 4'd3; rd_addr2 = 4'd9;

    // Power-on reset
    @(negedge clk); #1;
    chk("rst_a_rd1", a_rd1, 16'h0000);
    chk("rst_a_rd2", a_rd2, 16'h0000);
    chk("rst_a_err", 16'(a_err), 16'h0000);
    chk("rst_b_rd1", b_rd1, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Load R3, then asynchronous reset between edges
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
    @(negedge clk);
    wr_en = 1'b0; #1;
    chk("t1_a_r3", a_rd1, 16'h1234);
    chk("t1_b_r3", b_rd1, 16'h1234);
    rst_n = 1'b0; #1;
    chk("t1_a_r3_rst", a_rd1, 16'h0000);
    chk("t1_b_r3_rst", b_rd1, 16'h0000);
    chk("t1_a_err", 16'(a_err), 16'h0000);
    #1 rst_n = 1'b1;

    // 2. Write R5 while reading it: forwarded in A, old value in B
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr1 = 4'd5; rd_addr2 = 4'd5; #1;
    chk("t2_a_byp1", a_rd1, 16'hBEEF);
    chk("t2_a_byp2", a_rd2, 16'hBEEF);
    chk("t2_b_old1", b_rd1, 16'h0000);
    chk("t2_onehot", u_dut.w_reg_en, 16'h0020);
    @(negedge clk);
    wr_en = 1'b0; #1;
    chk("t2_onehot_idle", u_dut.w_reg_en, 16'h0000);
    chk("t2_a_rd1", a_rd1, 16'hBEEF);
    chk("t2_a_rd2", a_rd2, 16'hBEEF);
    chk("t2_b_rd1", b_rd1, 16'hBEEF);
    chk("t2_b_rd2", b_rd2, 16'hBEEF);
    rd_addr1 = 4'd4; rd_addr2 = 4'd6; #1;
    chk("t2_a_r4", a_rd1, 16'h0000);
    chk("t2_a_r6", a_rd2, 16'h0000);

    // 3. Bypass on port 1 only
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h00A5; rd_addr1 = 4'd7; rd_addr2 = 4'd5; #1;
    chk("t3_a_byp", a_rd1, 16'h00A5);
    chk("t3_b_old", b_rd1, 16'h0000);
    chk("t3_a_rd2", a_rd2, 16'hBEEF);
    chk("t3_onehot", u_dut.w_reg_en, 16'h0080);
    @(negedge clk);
    wr_en = 1'b0; #1;
    chk("t3_a_r7", a_rd1, 16'h00A5);
    chk("t3_b_r7", b_rd1, 16'h00A5);

    // 4. Write to R0
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; rd_addr1 = 4'd0; rd_addr2 = 4'd0; #1;
    chk("t4_a_r0_byp", a_rd1, 16'h0000);
    chk("t4_b_r0_old", b_rd1, 16'h0000);
    chk("t4_a_err_pre", 16'(a_err), 16'h0000);
    @(negedge clk);
    wr_en = 1'b0; #1;
    chk("t4_a_r0", a_rd1, 16'h0000);
    chk("t4_a_r0_p2", a_rd2, 16'h0000);
    chk("t4_b_r0", b_rd1, 16'hFFFF);
    chk("t4_a_err", 16'(a_err), 16'h0001);
    chk("t4_b_err", 16'(b_err), 16'h0000);
    @(negedge clk); #1;
    chk("t4_a_err_clr", 16'(a_err), 16'h0000);

    // 5. Demux sweep over every register
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i); #1;
      chk($sformatf("t5_onehot_%0d", i), u_dut.w_reg_en, 16'(1) << i);
      @(negedge clk);
    end
    wr_en = 1'b0; #1;
    chk("t5_onehot_idle", u_dut.w_reg_en, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      rd_addr1 = 4'(i); rd_addr2 = 4'(15 - i); #1;
      chk($sformatf("t5_a_rd1_%0d", i), a_rd1, (i == 0) ? 16'h0000 : 16'h1000 + 16'(i));
      chk($sformatf("t5_a_rd2_%0d", i), a_rd2, (i == 15) ? 16'h0000 : 16'h100F - 16'(i));
      chk($sformatf("t5_b_rd1_%0d", i), b_rd1, 16'h1000 + 16'(i));
    end

    // 6. Reset asserted during a write to R9, then first write after release
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 16'h5A5A; rd_addr1 = 4'd9; rd_addr2 = 4'd5; #1;
    chk("t6_a_byp", a_rd1, 16'h5A5A);
    rst_n = 1'b0; #1;
    chk("t6_a_rst_nobyp", a_rd1, 16'h0000);
    chk("t6_b_rst", b_rd1, 16'h0000);
    @(negedge clk); #1;
    chk("t6_a_r9_held", a_rd1, 16'h0000);
    chk("t6_b_r9_held", b_rd1, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; #1;
    chk("t6_a_r9", a_rd1, 16'h5A5A);
    chk("t6_b_r9", b_rd1, 16'h5A5A);
    chk("t6_a_r5_clr", a_rd2, 16'h0000);
    chk("t6_b_r5_clr", b_rd2, 16'h0000);

    // Back-to-back writes to the same register: last one wins
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'h1111; rd_addr1 = 4'd12;
    @(negedge clk);
    wr_data = 16'h2222;
    @(negedge clk);
    wr_en = 1'b0; #1;
    chk("b2b_a_r12", a_rd1, 16'h2222);
    chk("b2b_b_r12", b_rd1, 16'h2222);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
